hicore_clint: RTL and testbench

Machine-level core-local interruptor for HiCore. It holds the 64-bit `mtime` counter, the `mtimecmp` compare register and the `msip` software-interrupt bit. These are accessed over a single-outstanding memory-mapped request/response port. The block drives the `m_time_irq` and `m_soft_irq` inputs of the core's decode/CSR stage.

---
 rtl/hicore_clint.sv | 211 +++++++++++++++++++++
 tb/tb_hicore_clint.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_clint.sv
// hicore_clint -- machine-level core-local interruptor.
//
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and
// the msip software-interrupt bit behind a single-outstanding
// request/response port, and drives the core's machine timer and software
// interrupt lines.
//
// Optional feature macro: HICORE_MTIME_PRESCALER_EN
//   defined   : mtime advances once every PRESCALE_DIV clock cycles
//   undefined : mtime advances every clock cycle (PRESCALE_DIV unused)
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (accept = valid & ready)
//   req_we, req_addr        1 = write / 0 = read, byte offset in the window
//   req_wdata               full-word write data
//   rsp_valid/rsp_ready     response handshake, one response outstanding
//   rsp_rdata, rsp_err      read data (0 on writes/errors), address error
//   m_time_irq              registered (mtime >= mtimecmp), level
//   m_soft_irq              msip bit, level

module hicore_clint #(
  parameter int PRESCALE_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_time_irq,
  output logic        m_soft_irq
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO   = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI   = 16'h4004;
  localparam logic [15:0] ADDR_TIME_LO  = 16'hBFF8;
  localparam logic [15:0] ADDR_TIME_HI  = 16'hBFFC;

  // Reject an out-of-range prescaler divider at elaboration time.
  if ((PRESCALE_DIV < 2) || (PRESCALE_DIV > 65535)) begin : g_div_range
    $error("hicore_clint: PRESCALE_DIV must be within 2..65535");
  end

  logic        accept_s;
  logic        wr_s;
  logic        time_wr_s;
  logic        tick_s;
  logic        sel_msip_s;
  logic        sel_cmp_lo_s;
  logic        sel_cmp_hi_s;
  logic        sel_time_lo_s;
  logic        sel_time_hi_s;
  logic        addr_err_s;
  logic [31:0] rd_data_s;

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic        time_irq_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  // A new request can enter whenever the response slot is empty or draining.
  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign wr_s      = accept_s && req_we;
  assign time_wr_s = wr_s && (sel_time_lo_s || sel_time_hi_s);

  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_err    = rsp_err_r;
  assign m_time_irq = time_irq_r;
  assign m_soft_irq = msip_r;

  // Address decode. Only exact word offsets match, so any address with
  // req_addr[1:0] != 0 falls into the error branch as well.
  always_comb begin
    sel_msip_s    = 1'b0;
    sel_cmp_lo_s  = 1'b0;
    sel_cmp_hi_s  = 1'b0;
    sel_time_lo_s = 1'b0;
    sel_time_hi_s = 1'b0;
    addr_err_s    = 1'b0;
    case (req_addr)
      ADDR_MSIP:    sel_msip_s    = 1'b1;
      ADDR_CMP_LO:  sel_cmp_lo_s  = 1'b1;
      ADDR_CMP_HI:  sel_cmp_hi_s  = 1'b1;
      ADDR_TIME_LO: sel_time_lo_s = 1'b1;
      ADDR_TIME_HI: sel_time_hi_s = 1'b1;
      default:      addr_err_s    = 1'b1;
    endcase
  end

  // Read mux over the current register values (before this cycle's tick).
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (sel_msip_s) begin
      rd_data_s = {31'h0000_0000, msip_r};
    end else if (sel_cmp_lo_s) begin
      rd_data_s = mtimecmp_r[31:0];
    end else if (sel_cmp_hi_s) begin
      rd_data_s = mtimecmp_r[63:32];
    end else if (sel_time_lo_s) begin
      rd_data_s = mtime_r[31:0];
    end else if (sel_time_hi_s) begin
      rd_data_s = mtime_r[63:32];
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

`ifdef HICORE_MTIME_PRESCALER_EN
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE_DIV - 1);

  logic [15:0] presc_cnt_r;

  assign tick_s = (presc_cnt_r == PRESC_LAST);

  // Prescaler: restarts its period on every software write to mtime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_r <= 16'd0;
    end else if (time_wr_s || tick_s) begin
      presc_cnt_r <= 16'd0;
    end else begin
      presc_cnt_r <= presc_cnt_r + 16'd1;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // mtime: a software write to one half wins over the tick; the other half
  // holds, so no carry or increment is applied in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_r <= 64'h0000_0000_0000_0000;
    end else if (wr_s && sel_time_lo_s) begin
      mtime_r[31:0] <= req_wdata;
    end else if (wr_s && sel_time_hi_s) begin
      mtime_r[63:32] <= req_wdata;
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end else begin
      mtime_r <= mtime_r;
    end
  end

  // mtimecmp register, written one half at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_s && sel_cmp_lo_s) begin
      mtimecmp_r[31:0] <= req_wdata;
    end else if (wr_s && sel_cmp_hi_s) begin
      mtimecmp_r[63:32] <= req_wdata;
    end else begin
      mtimecmp_r <= mtimecmp_r;
    end
  end

  // msip bit; upper bits of the word are not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_r <= 1'b0;
    end else if (wr_s && sel_msip_s) begin
      msip_r <= req_wdata[0];
    end else begin
      msip_r <= msip_r;
    end
  end

  // Timer interrupt: registered compare of the current register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_irq_r <= 1'b0;
    end else begin
      time_irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  // Response slot: loaded on acceptance, held until the requester takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= req_we ? 32'h0000_0000 : rd_data_s;
      rsp_err_r   <= addr_err_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_rdata_r <= rsp_rdata_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

endmodule

// File: tb/tb_hicore_clint.sv
// Self-checking bench for hicore_clint. The reference model keeps, per
// register, a history of (effective cycle, value) events; mtime at cycle t is
// the latest written base plus elapsed ticks.
module tb_hicore_clint;

`ifdef HICORE_MTIME_PRESCALER_EN
  localparam int DIV_M = 4;
`else
  localparam int DIV_M = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_time_irq;
  logic        m_soft_irq;

  hicore_clint #(.PRESCALE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_time_irq(m_time_irq), .m_soft_irq(m_soft_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  int rst_cyc = 0;

  typedef struct { int cyc; logic [63:0] val; } ev_t;
  ev_t time_q[$];
  ev_t cmp_q[$];
  ev_t msip_q[$];

  // which: 0 = mtime, 1 = mtimecmp, 2 = msip
  function automatic logic [63:0] hist(input int which, input int t);
    logic [63:0] v;
    bit found;
    v = 64'h0;
    found = 1'b0;
    case (which)
      0: for (int i = time_q.size() - 1; i >= 0 && !found; i--)
           if (time_q[i].cyc <= t) begin
             v = time_q[i].val + 64'((t - time_q[i].cyc) / DIV_M);
             found = 1'b1;
           end
      1: for (int i = cmp_q.size() - 1; i >= 0 && !found; i--)
           if (cmp_q[i].cyc <= t) begin v = cmp_q[i].val; found = 1'b1; end
      default: for (int i = msip_q.size() - 1; i >= 0 && !found; i--)
           if (msip_q[i].cyc <= t) begin v = msip_q[i].val; found = 1'b1; end
    endcase
    return v;
  endfunction

  function automatic bit mapped(input logic [15:0] a);
    return (a == 16'h0000) || (a == 16'h4000) || (a == 16'h4004) ||
           (a == 16'hBFF8) || (a == 16'hBFFC);
  endfunction

  function automatic logic [31:0] exp_read(input logic [15:0] a, input int t);
    logic [63:0] v;
    case (a)
      16'h0000: begin v = hist(2, t); return {31'h0, v[0]}; end
      16'h4000: begin v = hist(1, t); return v[31:0]; end
      16'h4004: begin v = hist(1, t); return v[63:32]; end
      16'hBFF8: begin v = hist(0, t); return v[31:0]; end
      16'hBFFC: begin v = hist(0, t); return v[63:32]; end
      default:  return 32'h0;
    endcase
  endfunction

  // A write accepted in cycle c is visible from cycle c+1.
  function automatic void model_write(input logic [15:0] a, input logic [31:0] wd, input int c);
    logic [63:0] cur;
    case (a)
      16'h0000: msip_q.push_back('{cyc: c + 1, val: {63'h0, wd[0]}});
      16'h4000: begin cur = hist(1, c); cmp_q.push_back('{cyc: c + 1, val: {cur[63:32], wd}}); end
      16'h4004: begin cur = hist(1, c); cmp_q.push_back('{cyc: c + 1, val: {wd, cur[31:0]}}); end
      16'hBFF8: begin cur = hist(0, c); time_q.push_back('{cyc: c + 1, val: {cur[63:32], wd}}); end
      16'hBFFC: begin cur = hist(0, c); time_q.push_back('{cyc: c + 1, val: {wd, cur[31:0]}}); end
      default: ;
    endcase
  endfunction

  function automatic void model_reset(input int r);
    time_q.delete(); cmp_q.delete(); msip_q.delete();
    time_q.push_back('{cyc: r, val: 64'h0});
    cmp_q.push_back('{cyc: r, val: 64'hFFFF_FFFF_FFFF_FFFF});
    msip_q.push_back('{cyc: r, val: 64'h0});
  endfunction

  // Continuous interrupt monitor against the model.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [63:0] ms;
      logic exp_ti;
      exp_ti = hist(0, cyc - 1) >= hist(1, cyc - 1);
      ms = hist(2, cyc);
      n_tests++;
      if (m_time_irq !== exp_ti) begin
        n_fail++;
        $display("FAIL mon_time_irq cyc=%0d: got %b expected %b", cyc, m_time_irq, exp_ti);
      end
      n_tests++;
      if (m_soft_irq !== ms[0]) begin
        n_fail++;
        $display("FAIL mon_soft_irq cyc=%0d: got %b expected %b", cyc, m_soft_irq, ms[0]);
      end
    end
  end

  // One transaction, starting at a negedge; returns at the negedge where the
  // response is visible. Consecutive calls run back to back.
  task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int c);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    #1;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 20) begin
      n_tests++; n_fail++;
      $display("FAIL bus_accept_timeout addr=%h: req_ready=%b required 1", a, req_ready);
    end
    c = cyc;
    if (we) model_write(a, wd, c);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bus_rsp_valid addr=%h: got %b expected 1", a, rsp_valid);
    end
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int c;
    mon_en = 1'b0; rst_n = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, rsp_err, m_time_irq, m_soft_irq, rsp_rdata} !== {5'b10000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b_%h expected 10000_00000000",
               {req_ready, rsp_valid, rsp_err, m_time_irq, m_soft_irq}, rsp_rdata);
    end
    rst_n = 1'b1; rst_cyc = cyc; model_reset(rst_cyc);
    bus(1'b0, 16'hBFF8, 32'h0, rd, er, c);
    mon_en = 1'b1;
    n_tests++;
    if ({er, rd} !== {1'b0, 32'((c - rst_cyc) / DIV_M)}) begin
      n_fail++;
      $display("FAIL reset_mtime_lo: got err=%b %h expected err=0 %h", er, rd, 32'((c - rst_cyc) / DIV_M));
    end
    bus(1'b0, 16'hBFFC, 32'h0, rd, er, c);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mtime_hi: got err=%b %h expected err=0 00000000", er, rd);
    end
    bus(1'b0, 16'h4004, 32'h0, rd, er, c);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL reset_cmp_hi: got err=%b %h expected err=0 ffffffff", er, rd);
    end
  endtask

  task automatic test_soft_irq();
    logic [31:0] rd; logic er; int c;
    bus(1'b1, 16'h0000, 32'h0000_0003, rd, er, c);
    n_tests++;
    if (m_soft_irq !== 1'b1) begin
      n_fail++; $display("FAIL soft_irq_rise: got %b expected 1", m_soft_irq);
    end
    bus(1'b0, 16'h0000, 32'h0, rd, er, c);
    n_tests++;
    if (rd !== 32'h0000_0001) begin
      n_fail++; $display("FAIL msip_read: got %h expected 00000001", rd);
    end
    bus(1'b1, 16'h0000, 32'h0, rd, er, c);
    n_tests++;
    if (m_soft_irq !== 1'b0) begin
      n_fail++; $display("FAIL soft_irq_fall: got %b expected 0", m_soft_irq);
    end
  endtask

  task automatic test_timer_carry();
    logic [31:0] rd; logic er; int c; bit rose; int t_rise;
    logic [63:0] mt;
    bus(1'b1, 16'h4000, 32'h0000_0001, rd, er, c);
    bus(1'b1, 16'h4004, 32'h0000_0001, rd, er, c);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFD, rd, er, c);
    bus(1'b1, 16'hBFFC, 32'h0000_0000, rd, er, c);
    rose = 1'b0; t_rise = 0;
    for (int k = 0; k < 20 * DIV_M && !rose; k++) begin
      @(negedge clk);
      if (m_time_irq === 1'b1) begin rose = 1'b1; t_rise = cyc; end
    end
    mt = hist(0, t_rise - 1);
    n_tests++;
    if (!rose || mt !== 64'h0000_0001_0000_0001) begin
      n_fail++;
      $display("FAIL timer_irq_rise: rose=%b mtime_before=%h expected rose=1 0000000100000001", rose, mt);
    end
    bus(1'b0, 16'hBFFC, 32'h0, rd, er, c);
    n_tests++;
    if (rd !== 32'h0000_0001) begin
      n_fail++; $display("FAIL carry_hi: got %h expected 00000001", rd);
    end
    bus(1'b1, 16'h4004, 32'hFFFF_FFFF, rd, er, c);
    n_tests++;
    if (m_time_irq !== 1'b1) begin
      n_fail++; $display("FAIL timer_irq_hold: got %b expected 1", m_time_irq);
    end
    @(negedge clk);
    n_tests++;
    if (m_time_irq !== 1'b0) begin
      n_fail++; $display("FAIL timer_irq_clear: got %b expected 0", m_time_irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int c; int hi_cnt;
    bus(1'b1, 16'h4000, 32'hFFFF_FFFF, rd, er, c);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er, c);
    bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, er, c);
    hi_cnt = 0;
    for (int k = 0; k < 4 * DIV_M + 4; k++) begin
      if (m_time_irq === 1'b1) hi_cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (hi_cnt != DIV_M) begin
      n_fail++; $display("FAIL wrap_irq_cycles: got %0d expected %0d", hi_cnt, DIV_M);
    end
    bus(1'b0, 16'hBFFC, 32'h0, rd, er, c);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL wrap_hi: got %h expected 00000000", rd);
    end
    bus(1'b0, 16'hBFF8, 32'h0, rd, er, c);
    n_tests++;
    if (rd !== exp_read(16'hBFF8, c)) begin
      n_fail++; $display("FAIL wrap_lo: got %h expected %h", rd, exp_read(16'hBFF8, c));
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int c;
    logic [15:0] tbl [4];
    tbl = '{16'h0000, 16'h4000, 16'h4004, 16'hBFFC};
    bus(1'b0, 16'h0002, 32'h0, rd, er, c);
    n_tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_misaligned_read: got err=%b %h expected err=1 00000000", er, rd);
    end
    bus(1'b1, 16'h1234, $urandom, rd, er, c);
    n_tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_unmapped_write: got err=%b %h expected err=1 00000000", er, rd);
    end
    bus(1'b1, 16'h4001, $urandom, rd, er, c);
    n_tests++;
    if ({er, rd} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_misaligned_write: got err=%b %h expected err=1 00000000", er, rd);
    end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, tbl[i], 32'h0, rd, er, c);
      n_tests++;
      if ({er, rd} !== {1'b0, exp_read(tbl[i], c)}) begin
        n_fail++;
        $display("FAIL err_no_side_effect addr=%h: got err=%b %h expected err=0 %h", tbl[i], er, rd, exp_read(tbl[i], c));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000;
    exp = exp_read(16'h4000, cyc);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b010, exp}) begin
        n_fail++;
        $display("FAIL backpressure_hold k=%0d: got rdy=%b vld=%b err=%b %h expected rdy=0 vld=1 err=0 %h",
                 k, req_ready, rsp_valid, rsp_err, rsp_rdata, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL backpressure_release: got rdy=%b vld=%b expected rdy=1 vld=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int c; int k;
    logic [15:0] a; logic we; logic [31:0] wd;
    logic [15:0] tbl [5];
    tbl = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      a = (k < 5) ? tbl[k] : 16'($urandom);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      bus(we, a, wd, rd, er, c);
      n_tests++;
      if ({er, rd} !== {!mapped(a), (we ? 32'h0 : exp_read(a, c))}) begin
        n_fail++;
        $display("FAIL random i=%0d we=%b addr=%h: got err=%b %h expected err=%b %h",
                 i, we, a, er, rd, !mapped(a), (we ? 32'h0 : exp_read(a, c)));
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

`ifdef HICORE_MTIME_PRESCALER_EN
  task automatic test_prescaler();
    logic [31:0] rd; logic er; int c;
    bus(1'b1, 16'hBFF8, 32'd10, rd, er, c);
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 16'hBFF8, 32'h0, rd, er, c);
      n_tests++;
      if (rd !== ((i < 4) ? 32'd10 : 32'd11)) begin
        n_fail++;
        $display("FAIL prescaler_read i=%0d: got %0d expected %0d", i, rd, (i < 4) ? 10 : 11);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int c;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hBFFC;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pending: got %b expected 1", rsp_valid);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rst_cyc = cyc; model_reset(rst_cyc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_dropped k=%0d: got %b expected 0", k, rsp_valid);
      end
    end
    bus(1'b0, 16'hBFF8, 32'h0, rd, er, c);
    mon_en = 1'b1;
    n_tests++;
    if (rd !== 32'((c - rst_cyc) / DIV_M)) begin
      n_fail++; $display("FAIL midreset_mtime: got %h expected %h", rd, 32'((c - rst_cyc) / DIV_M));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_soft_irq();
    test_timer_carry();
    test_wrap();
    test_errors();
    test_backpressure();
    test_random();
`ifdef HICORE_MTIME_PRESCALER_EN
    test_prescaler();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
